rob_multiport: RTL and testbench

- Parametrised reorder buffer: in-order allocation at the tail, out-of-order completion from NPORTS writeback ports, in-order single-entry commit at the head.
- Commit drives the register-file write port and the exception interface.
- Adds over the previous generation: tail allocation with full/empty tracking, a configurable port count and depth, one-hot source type, and automatic flush on a committed exception.

---
 rtl/rob_multiport.sv | 183 ++++++++++++++++++
 tb/tb_rob_multiport.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
// Reorder buffer: allocates in order at the tail, completes out of order from NPORTS
// writeback ports, and commits one entry per cycle from the head.
module rob_multiport #(
    parameter int unsigned SLOTS        = 16,
    parameter int unsigned IDX_BITS     = 4,
    parameter int unsigned NPORTS       = 5,
    parameter int unsigned ARCH_BITS    = 32,
    parameter int unsigned REG_IDX_BITS = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    // Allocation
    input  logic                           alloc_req,
    output logic                           alloc_ready,
    output logic [IDX_BITS-1:0]            alloc_idx,
    // Writeback
    input  logic [NPORTS-1:0]              wb_valid,
    input  logic [NPORTS*IDX_BITS-1:0]     wb_idx,
    input  logic [NPORTS-1:0]              wb_except,
    input  logic [NPORTS*ARCH_BITS-1:0]    wb_pc,
    input  logic [NPORTS*ARCH_BITS-1:0]    wb_addr,
    input  logic [NPORTS*ARCH_BITS-1:0]    wb_data,
    input  logic [NPORTS*REG_IDX_BITS-1:0] wb_dst,
    input  logic [NPORTS-1:0]              wb_we,
    // Commit
    output logic                           commit_valid,
    output logic [IDX_BITS-1:0]            commit_idx,
    output logic                           except,
    output logic [ARCH_BITS-1:0]           address,
    output logic [ARCH_BITS-1:0]           pc,
    output logic [NPORTS-1:0]              commit_type,
    output logic                           wEnable,
    output logic [REG_IDX_BITS-1:0]        wDstReg,
    output logic [ARCH_BITS-1:0]           wData,
    // Occupancy
    output logic [IDX_BITS:0]              count,
    output logic                           empty,
    output logic                           full
);

    localparam int unsigned CNT_BITS = IDX_BITS + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(SLOTS);

    // Control state
    logic [SLOTS-1:0]    alloc_q, alloc_d;
    logic [SLOTS-1:0]    done_q, done_d;
    logic [IDX_BITS-1:0] head_q, head_d;
    logic [IDX_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    // Payload state, deliberately left out of reset
    logic [ARCH_BITS-1:0]    pc_q   [SLOTS];
    logic [ARCH_BITS-1:0]    addr_q [SLOTS];
    logic [ARCH_BITS-1:0]    data_q [SLOTS];
    logic [REG_IDX_BITS-1:0] dst_q  [SLOTS];
    logic [NPORTS-1:0]       type_q [SLOTS];
    logic [SLOTS-1:0]        we_q;
    logic [SLOTS-1:0]        exc_q;

    // Per-slot winning writeback
    logic [SLOTS-1:0]        wb_hit;
    logic [NPORTS-1:0]       wb_oh      [SLOTS];
    logic [ARCH_BITS-1:0]    wb_pc_sel  [SLOTS];
    logic [ARCH_BITS-1:0]    wb_addr_sel[SLOTS];
    logic [ARCH_BITS-1:0]    wb_data_sel[SLOTS];
    logic [REG_IDX_BITS-1:0] wb_dst_sel [SLOTS];
    logic [SLOTS-1:0]        wb_we_sel;
    logic [SLOTS-1:0]        wb_exc_sel;

    logic flush_req;
    logic commit_fire;
    logic alloc_fire;

    assign flush_req = rst | clear;

    // Head view; every commit output is combinational from here
    assign commit_valid = alloc_q[head_q] & done_q[head_q];
    assign except       = commit_valid & exc_q[head_q];
    assign commit_fire  = commit_valid & ~except;
    assign commit_idx   = head_q;
    assign address      = addr_q[head_q];
    assign pc           = pc_q[head_q];
    assign commit_type  = type_q[head_q];
    assign wEnable      = commit_valid & we_q[head_q] & ~except;
    assign wDstReg      = dst_q[head_q];
    assign wData        = data_q[head_q];

    // Registered count only, so a full ROB refuses even while it commits
    assign alloc_ready = (count_q < FULL_CNT) & ~except;
    assign alloc_fire  = alloc_req & alloc_ready;
    assign alloc_idx   = tail_q;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Scan ports from high to low so the lowest-numbered port overwrites last and wins
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            wb_hit[s]      = 1'b0;
            wb_oh[s]       = '0;
            wb_pc_sel[s]   = '0;
            wb_addr_sel[s] = '0;
            wb_data_sel[s] = '0;
            wb_dst_sel[s]  = '0;
            wb_we_sel[s]   = 1'b0;
            wb_exc_sel[s]  = 1'b0;
            for (int p = NPORTS - 1; p >= 0; p--) begin
                if (wb_valid[p] && alloc_q[s] && !flush_req &&
                    (wb_idx[p*IDX_BITS +: IDX_BITS] == IDX_BITS'(s))) begin
                    wb_hit[s]      = 1'b1;
                    wb_oh[s]       = NPORTS'(1) << p;
                    wb_pc_sel[s]   = wb_pc[p*ARCH_BITS +: ARCH_BITS];
                    wb_addr_sel[s] = wb_addr[p*ARCH_BITS +: ARCH_BITS];
                    wb_data_sel[s] = wb_data[p*ARCH_BITS +: ARCH_BITS];
                    wb_dst_sel[s]  = wb_dst[p*REG_IDX_BITS +: REG_IDX_BITS];
                    wb_we_sel[s]   = wb_we[p];
                    wb_exc_sel[s]  = wb_except[p];
                end
            end
        end
    end

    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q | wb_hit;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_BITS'(alloc_fire) - CNT_BITS'(commit_fire);

        if (commit_fire) begin
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (alloc_fire) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + 1'b1;
        end

        // A committed exception flushes everything, like clear
        if (except) begin
            alloc_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < SLOTS; s++) begin
            if (wb_hit[s]) begin
                pc_q[s]   <= wb_pc_sel[s];
                addr_q[s] <= wb_addr_sel[s];
                data_q[s] <= wb_data_sel[s];
                dst_q[s]  <= wb_dst_sel[s];
                type_q[s] <= wb_oh[s];
                we_q[s]   <= wb_we_sel[s];
                exc_q[s]  <= wb_exc_sel[s];
            end
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: table-driven allocation/writeback rows, hand-written corner
// sequences, and a scoreboard of allocated indices checked against every commit.
module tb_rob_multiport;

    localparam int unsigned SLOTS        = 16;
    localparam int unsigned IDX_BITS     = 4;
    localparam int unsigned NPORTS       = 5;
    localparam int unsigned ARCH_BITS    = 32;
    localparam int unsigned REG_IDX_BITS = 5;

    logic                           clk = 1'b0;
    logic                           rst, clear, alloc_req;
    logic                           alloc_ready;
    logic [IDX_BITS-1:0]            alloc_idx;
    logic [NPORTS-1:0]              wb_valid, wb_except, wb_we;
    logic [NPORTS*IDX_BITS-1:0]     wb_idx;
    logic [NPORTS*ARCH_BITS-1:0]    wb_pc, wb_addr, wb_data;
    logic [NPORTS*REG_IDX_BITS-1:0] wb_dst;
    logic                           commit_valid, except, wEnable, empty, full;
    logic [IDX_BITS-1:0]            commit_idx;
    logic [ARCH_BITS-1:0]           address, pc, wData;
    logic [NPORTS-1:0]              commit_type;
    logic [REG_IDX_BITS-1:0]        wDstReg;
    logic [IDX_BITS:0]              count;

    rob_multiport #(
        .SLOTS(SLOTS), .IDX_BITS(IDX_BITS), .NPORTS(NPORTS),
        .ARCH_BITS(ARCH_BITS), .REG_IDX_BITS(REG_IDX_BITS)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_except(wb_except),
        .wb_pc(wb_pc), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_dst(wb_dst), .wb_we(wb_we),
        .commit_valid(commit_valid), .commit_idx(commit_idx), .except(except),
        .address(address), .pc(pc), .commit_type(commit_type),
        .wEnable(wEnable), .wDstReg(wDstReg), .wData(wData),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ARCH_BITS-1:0] pc;
        logic [ARCH_BITS-1:0] addr;
        logic [ARCH_BITS-1:0] data;
        int                   dst;
        logic                 we;
        logic                 exc;
        logic [NPORTS-1:0]    typ;
    } exp_t;

    typedef struct {
        bit          alloc;
        bit          wbv;
        int          port;
        int          idx;
        logic [31:0] data;
        int          dst;
        bit          e_ready;
        int          e_aidx;
        int          e_count;
        bit          e_cv;
        bit          e_empty;
    } vec_t;

    exp_t model [SLOTS];
    int   sb [$];
    vec_t tbl [6];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wb(input int p, input int idx, input logic exc, input logic [31:0] vpc,
                      input logic [31:0] vaddr, input logic [31:0] vdata, input int dst,
                      input logic we);
        wb_valid[p]                          = 1'b1;
        wb_except[p]                         = exc;
        wb_we[p]                             = we;
        wb_idx[p*IDX_BITS +: IDX_BITS]       = IDX_BITS'(idx);
        wb_pc[p*ARCH_BITS +: ARCH_BITS]      = vpc;
        wb_addr[p*ARCH_BITS +: ARCH_BITS]    = vaddr;
        wb_data[p*ARCH_BITS +: ARCH_BITS]    = vdata;
        wb_dst[p*REG_IDX_BITS +: REG_IDX_BITS] = REG_IDX_BITS'(dst);
        model[idx] = '{pc: vpc, addr: vaddr, data: vdata, dst: dst, we: we, exc: exc,
                       typ: NPORTS'(1) << p};
    endtask

    task automatic observe_commit();
        int   idx;
        exp_t m;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL commit_unexpected: got commit idx %0d, expected none", commit_idx);
        end else begin
            idx = sb.pop_front();
            m   = model[idx];
            chk("commit_idx", commit_idx, idx);
            chk("commit_pc", pc, m.pc);
            chk("commit_address", address, m.addr);
            chk("commit_wData", wData, m.data);
            chk("commit_wDstReg", wDstReg, m.dst);
            chk("commit_wEnable", wEnable, m.we & ~m.exc);
            chk("commit_type", commit_type, m.typ);
            chk("commit_except", except, m.exc);
            if (m.exc) sb.delete();
        end
    endtask

    // One clock: observe the settled commit, take the edge, then drop writeback strobes
    task automatic tick();
        #1;
        if (commit_valid === 1'b1 && !clear && !rst) observe_commit();
        @(posedge clk);
        #1;
        wb_valid  = '0;
        wb_except = '0;
        wb_we     = '0;
    endtask

    task automatic do_clear();
        alloc_req = 1'b0;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
    endtask

    task automatic alloc_n(input int n);
        alloc_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            if (alloc_ready) sb.push_back(int'(alloc_idx));
            tick();
        end
        alloc_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; alloc_req = 1'b0;
        wb_valid = '0; wb_except = '0; wb_we = '0; wb_idx = '0;
        wb_pc = '0; wb_addr = '0; wb_data = '0; wb_dst = '0;

        //         alloc wbv port idx data    dst rdy aidx cnt cv empty
        tbl[0] = '{1'b1, 1'b0, 0, 0, 32'h0,  0, 1'b1, 0, 0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 0, 0, 32'h0,  0, 1'b1, 1, 1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 0, 0, 32'h0,  0, 1'b1, 2, 2, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 2, 0, 32'hAB, 7, 1'b1, 3, 3, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 0, 0, 32'h0,  0, 1'b1, 3, 3, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 0, 0, 32'h0,  0, 1'b1, 3, 2, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_except", except, 0);
        chk("rst_wEnable", wEnable, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_idx", alloc_idx, 0);
        chk("rst_count", count, 0);

        // Basic allocate / writeback / commit rows
        for (int r = 0; r < 6; r++) begin
            alloc_req = tbl[r].alloc;
            if (tbl[r].wbv) wb(tbl[r].port, tbl[r].idx, 1'b0, 32'h100, 32'h200,
                               tbl[r].data, tbl[r].dst, 1'b1);
            #1;
            chk($sformatf("row%0d_alloc_ready", r), alloc_ready, tbl[r].e_ready);
            chk($sformatf("row%0d_alloc_idx", r), alloc_idx, tbl[r].e_aidx);
            chk($sformatf("row%0d_count", r), count, tbl[r].e_count);
            chk($sformatf("row%0d_commit_valid", r), commit_valid, tbl[r].e_cv);
            chk($sformatf("row%0d_empty", r), empty, tbl[r].e_empty);
            if (tbl[r].alloc && tbl[r].e_ready) sb.push_back(tbl[r].e_aidx);
            tick();
        end
        alloc_req = 1'b0;

        // Out-of-order completion, in-order commit
        do_clear();
        alloc_n(4);
        wb(4, 3, 1'b0, 32'h13, 32'h23, 32'h33, 3, 1'b1); tick();
        wb(1, 1, 1'b0, 32'h11, 32'h21, 32'h31, 1, 1'b1); tick();
        wb(3, 2, 1'b0, 32'h12, 32'h22, 32'h32, 2, 1'b0); tick();
        wb(0, 0, 1'b0, 32'h10, 32'h20, 32'h30, 4, 1'b1); tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("ooo_cv%0d", i), commit_valid, 1);
            tick();
        end
        chk("ooo_empty", empty, 1);
        chk("ooo_sb_drained", sb.size(), 0);

        // Fill, refuse the 17th, wrap the tail after one commit
        do_clear();
        alloc_n(SLOTS);
        chk("fill_full", full, 1);
        chk("fill_ready", alloc_ready, 0);
        chk("fill_count", count, SLOTS);
        alloc_req = 1'b1;
        tick();
        chk("extra_count", count, SLOTS);
        chk("extra_alloc_idx", alloc_idx, 0);
        wb(2, 0, 1'b0, 32'h50, 32'h60, 32'h70, 9, 1'b1);
        tick();
        chk("full_commit_cv", commit_valid, 1);
        chk("full_commit_ready", alloc_ready, 0);
        tick();
        chk("wrap_count", count, SLOTS - 1);
        chk("wrap_ready", alloc_ready, 1);
        chk("wrap_alloc_idx", alloc_idx, 0);
        sb.push_back(0);
        tick();
        alloc_req = 1'b0;
        chk("wrap_refill_count", count, SLOTS);
        chk("wrap_next_idx", alloc_idx, 1);

        // Two ports hitting one index: port0 wins
        do_clear();
        alloc_n(6);
        wb(3, 5, 1'b0, 32'h3333, 32'h3334, 32'h3335, 3, 1'b0);
        wb(0, 5, 1'b0, 32'h5555, 32'h5556, 32'h5557, 5, 1'b1);
        tick();
        for (int p = 0; p < 5; p++) wb(p, p, 1'b0, 32'h700 + p, 32'h800 + p, 32'h900 + p, p, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("same_idx_cv%0d", i), commit_valid, 1);
            tick();
        end
        chk("same_idx_sb_drained", sb.size(), 0);

        // Committed exception flushes the ROB
        do_clear();
        alloc_n(3);
        wb(1, 0, 1'b1, 32'h40, 32'h1000, 32'h0, 3, 1'b1);
        tick();
        alloc_req = 1'b1;
        #1;
        chk("exc_except", except, 1);
        chk("exc_pc", pc, 32'h40);
        chk("exc_address", address, 32'h1000);
        chk("exc_wEnable", wEnable, 0);
        chk("exc_ready", alloc_ready, 0);
        tick();
        alloc_req = 1'b0;
        #1;
        chk("exc_after_except", except, 0);
        chk("exc_after_empty", empty, 1);
        chk("exc_after_count", count, 0);
        chk("exc_after_alloc_idx", alloc_idx, 0);

        // clear with writebacks in flight
        do_clear();
        alloc_n(6);
        wb(1, 1, 1'b0, 32'h1, 32'h1, 32'h1, 1, 1'b1);
        wb(2, 2, 1'b0, 32'h2, 32'h2, 32'h2, 2, 1'b1);
        tick();
        clear = 1'b1;
        wb(0, 0, 1'b0, 32'h3, 32'h3, 32'h3, 3, 1'b1);
        wb(3, 3, 1'b0, 32'h4, 32'h4, 32'h4, 4, 1'b1);
        tick();
        clear = 1'b0;
        sb.delete();
        #1;
        chk("clr_empty", empty, 1);
        chk("clr_count", count, 0);
        chk("clr_cv", commit_valid, 0);
        tick();
        chk("clr_cv_later", commit_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
